// File: rtl/bitbang_pkg.sv
// Shared types and constants for the bit-banged host interface.
// Holds the TX state type, work/nonce geometry and a saturating add helper.
package bitbang_pkg;

    localparam int WORK_BITS  = 512;
    localparam int NONCE_BITS = 32;
    localparam int BYTE_BITS  = 8;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BITS = 1'b1
    } tx_state_t;

    // Byte idx of a nonce, idx 3 being the most significant byte.
    function automatic logic [BYTE_BITS-1:0] nonce_byte(input logic [NONCE_BITS-1:0] w,
                                                        input logic [1:0]            idx);
        return w[{idx, 3'b000} +: BYTE_BITS];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/bitbang_sync.sv
// SYNC_STAGES-flop synchroniser for one asynchronous host pin plus one edge flop.
// PULSE=1 gives a registered rising-edge pulse, PULSE=0 the delayed level aligned to it.
module bitbang_sync
    import bitbang_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit PULSE       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            last  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            last  <= chain[SYNC_STAGES-1];
        end
    end

    if (PULSE) begin : g_pulse
        logic rise;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rise <= 1'b0;
            end else begin
                rise <= chain[SYNC_STAGES-1] & ~last;
            end
        end
        assign q = rise;
    end else begin : g_level
        // Same delay as the pulse path so data and strobe stay aligned.
        assign q = last;
    end

endmodule

// File: rtl/bitbang_host_if.sv
// Host-side bit-banged work unit deserialiser and golden-nonce readback shifter.
// Define BITBANG_DROP_CNT_EN to add the saturating drop_cnt output.
module bitbang_host_if
    import bitbang_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WORK_BYTES  = 64,
    parameter int NONCE_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RxD,
    input  logic                    RxC,
    input  logic                    RxTxR,
    input  logic                    TxC,
    output logic                    TxD,
    output logic [WORK_BITS/2-1:0]  midstate,
    output logic [WORK_BITS/2-1:0]  data,
    output logic                    work_valid,
    input  logic [NONCE_BITS-1:0]   nonce_in,
    input  logic                    nonce_valid,
    output logic                    tx_busy
`ifdef BITBANG_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);

    localparam int BC_W     = $clog2(WORK_BYTES + 1);
    localparam int BL_W     = $clog2(NONCE_BYTES + 1);
    localparam int BUF_BITS = WORK_BYTES * BYTE_BITS;
    localparam logic [BC_W-1:0] FULL_CNT  = BC_W'(WORK_BYTES);
    localparam logic [BL_W-1:0] NONCE_CNT = BL_W'(NONCE_BYTES);

    logic rxd_s, rxc_rise, rxtxr_rise, txc_rise;

    bitbang_sync #(.SYNC_STAGES(SYNC_STAGES), .PULSE(1'b0)) u_sync_rxd (
        .clk(clk), .rst_n(rst_n), .d(RxD), .q(rxd_s));
    bitbang_sync #(.SYNC_STAGES(SYNC_STAGES), .PULSE(1'b1)) u_sync_rxc (
        .clk(clk), .rst_n(rst_n), .d(RxC), .q(rxc_rise));
    bitbang_sync #(.SYNC_STAGES(SYNC_STAGES), .PULSE(1'b1)) u_sync_rxtxr (
        .clk(clk), .rst_n(rst_n), .d(RxTxR), .q(rxtxr_rise));
    bitbang_sync #(.SYNC_STAGES(SYNC_STAGES), .PULSE(1'b1)) u_sync_txc (
        .clk(clk), .rst_n(rst_n), .d(TxC), .q(txc_rise));

    // ---------------- RX: work unit deserialiser ----------------
    logic [BUF_BITS-1:0]  rx_buf;
    logic [BYTE_BITS-1:0] byte_reg;
    logic [BYTE_BITS-1:0] next_byte;
    logic [BC_W-1:0]      byte_cnt;
    logic [2:0]           bit_cnt;
    logic                 overrun;
    logic                 commit;

    assign next_byte = {rxd_s, byte_reg[BYTE_BITS-1:1]};
    assign commit    = rxtxr_rise && (byte_cnt == FULL_CNT) && (bit_cnt == 3'd0) && !overrun;

    // A framing strobe always takes priority over a coincident bit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_buf     <= '0;
            byte_reg   <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            overrun    <= 1'b0;
            midstate   <= '0;
            data       <= '0;
            work_valid <= 1'b0;
        end else begin
            work_valid <= 1'b0;
            if (rxtxr_rise) begin
                if (commit) begin
                    midstate   <= rx_buf[BUF_BITS-1 -: WORK_BITS/2];
                    data       <= rx_buf[WORK_BITS/2-1:0];
                    work_valid <= 1'b1;
                end
                byte_cnt <= '0;
                bit_cnt  <= '0;
                overrun  <= 1'b0;
            end else if (rxc_rise) begin
                if (byte_cnt == FULL_CNT) begin
                    overrun <= 1'b1;
                end else begin
                    byte_reg <= next_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_buf   <= {rx_buf[BUF_BITS-BYTE_BITS-1:0], next_byte};
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- TX: nonce slots and poll shifter ----------------
    tx_state_t             state;
    logic [BYTE_BITS-1:0]  cur_byte;
    logic [2:0]            bit_idx;
    logic                  cur_live;
    logic [BL_W-1:0]       bytes_left, bytes_left_n;
    logic                  pend_valid, pend_valid_n;
    logic [NONCE_BITS-1:0] pend_nonce, pend_nonce_n;
    logic                  shad_valid, shad_valid_n;
    logic [NONCE_BITS-1:0] shad_nonce, shad_nonce_n;
    logic                  tx_start, byte_done;
`ifdef BITBANG_DROP_CNT_EN
    logic [1:0]            drop_inc;
`endif

    assign tx_start  = txc_rise && (state == TX_IDLE) && pend_valid &&
                       (bytes_left != '0) && !commit;
    assign byte_done = txc_rise && (state == TX_BITS) && (bit_idx == 3'd7);
    assign tx_busy   = pend_valid || shad_valid || (state == TX_BITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            TxD      <= 1'b0;
            cur_byte <= '0;
            bit_idx  <= '0;
        end else if (txc_rise) begin
            case (state)
                TX_IDLE: begin
                    if (tx_start) begin
                        TxD      <= 1'b1;
                        cur_byte <= nonce_byte(pend_nonce, 2'(bytes_left - BL_W'(1)));
                        bit_idx  <= '0;
                        state    <= TX_BITS;
                    end else begin
                        TxD <= 1'b0;
                    end
                end
                TX_BITS: begin
                    TxD     <= cur_byte[bit_idx];
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // cur_live marks that the byte on the wire still belongs to the pending
    // nonce; a flushed byte finishes shifting without touching the new slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_live <= 1'b0;
        end else if (commit) begin
            cur_live <= 1'b0;
        end else if (tx_start) begin
            cur_live <= 1'b1;
        end else if (byte_done) begin
            cur_live <= 1'b0;
        end
    end

    always_comb begin
        pend_valid_n = pend_valid;
        pend_nonce_n = pend_nonce;
        shad_valid_n = shad_valid;
        shad_nonce_n = shad_nonce;
        bytes_left_n = bytes_left;
`ifdef BITBANG_DROP_CNT_EN
        drop_inc = 2'd0;
`endif
        if (byte_done && cur_live) begin
            if (bytes_left == BL_W'(1)) begin
                if (shad_valid) begin
                    pend_nonce_n = shad_nonce;
                    bytes_left_n = NONCE_CNT;
                    shad_valid_n = 1'b0;
                end else begin
                    pend_valid_n = 1'b0;
                    bytes_left_n = '0;
                end
            end else begin
                bytes_left_n = bytes_left - BL_W'(1);
            end
        end
        if (nonce_valid) begin
            if (!pend_valid_n) begin
                pend_valid_n = 1'b1;
                pend_nonce_n = nonce_in;
                bytes_left_n = NONCE_CNT;
            end else begin
`ifdef BITBANG_DROP_CNT_EN
                if (shad_valid_n) drop_inc = 2'd1;
`endif
                shad_valid_n = 1'b1;
                shad_nonce_n = nonce_in;
            end
        end
        if (commit) begin
`ifdef BITBANG_DROP_CNT_EN
            drop_inc = drop_inc + {1'b0, pend_valid_n} + {1'b0, shad_valid_n};
`endif
            pend_valid_n = 1'b0;
            shad_valid_n = 1'b0;
            bytes_left_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_nonce <= '0;
            shad_valid <= 1'b0;
            shad_nonce <= '0;
            bytes_left <= '0;
        end else begin
            pend_valid <= pend_valid_n;
            pend_nonce <= pend_nonce_n;
            shad_valid <= shad_valid_n;
            shad_nonce <= shad_nonce_n;
            bytes_left <= bytes_left_n;
        end
    end

`ifdef BITBANG_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= sat_add8(drop_cnt, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_bitbang_host_if.sv
// Bench for bitbang_host_if: host-level model of frames and nonce readback streams.
// Build with BITBANG_DROP_CNT_EN defined to also check drop_cnt.
`timescale 1ns/1ps
module tb_bitbang_host_if;

    localparam logic [255:0] MID_VEC  =
        256'h2b3f8126_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_2619c0b5;
    localparam logic [255:0] DATA_VEC =
        256'h00000000_00000000_00000000_00000000_00000000_39f3001b_6b7b8d4d_c14bfc31;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         RxD, RxC, RxTxR, TxC;
    logic         TxD;
    logic [255:0] midstate, data;
    logic         work_valid;
    logic [31:0]  nonce_in;
    logic         nonce_valid;
    logic         tx_busy;
`ifdef BITBANG_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Host-level model state
    logic [255:0] model_mid, model_data;
    int           exp_commits = 0;
    int           wv_cycles   = 0;
    bit           hold;
    logic         rx_bits[$];
    logic [0:0]   exp_q[$];
    int           pend_left;
    bit           shad_v;
    logic [31:0]  shad_n;
    int           tx_pos;
    int           drops_exp;

    always #5 clk = ~clk;

    bitbang_host_if dut (
        .clk(clk), .rst_n(rst_n), .RxD(RxD), .RxC(RxC), .RxTxR(RxTxR), .TxC(TxC),
        .TxD(TxD), .midstate(midstate), .data(data), .work_valid(work_valid),
        .nonce_in(nonce_in), .nonce_valid(nonce_valid), .tx_busy(tx_busy)
`ifdef BITBANG_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Work outputs must always hold the last committed frame.
    always @(negedge clk) begin
        if (work_valid === 1'b1) wv_cycles++;
        if (!hold) begin
            checks++;
            if (midstate !== model_mid || data !== model_data) begin
                errors++;
                if (errors < 20)
                    $display("FAIL work_out: midstate %h data %h expected %h %h",
                             midstate, data, model_mid, model_data);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        cycles(1);
        RxC = 1'b1;
        cycles(3);
        RxC = 1'b0;
        cycles(3);
        rx_bits.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) send_bit(v[k]);
    endtask

    task automatic send_word(input logic [511:0] w, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = w[511 - 8*i -: 8];
            send_byte(b);
        end
    endtask

    task automatic push_stream(input logic [31:0] v);
        for (int j = 3; j >= 0; j--) begin
            exp_q.push_back(1'b1);
            for (int k = 0; k < 8; k++) exp_q.push_back(v[8*j + k]);
        end
    endtask

    // Exactly 512 bits since the last framing strobe commits; anything else does not.
    task automatic pulse_rxtxr();
        logic [511:0] w;
        int keep;
        hold  = 1'b1;
        RxTxR = 1'b1;
        cycles(3);
        RxTxR = 1'b0;
        cycles(6);
        if (rx_bits.size() == 512) begin
            for (int i = 0; i < 512; i++) w[511 - 8*(i/8) - 7 + (i%8)] = rx_bits[i];
            model_mid  = w[511:256];
            model_data = w[255:0];
            exp_commits++;
            drops_exp += ((pend_left > 0) ? 1 : 0) + (shad_v ? 1 : 0);
            keep = ((tx_pos % 9) == 0) ? 0 : 9 - (tx_pos % 9);
            while (exp_q.size() > keep) void'(exp_q.pop_back());
            pend_left = 0;
            shad_v    = 1'b0;
        end
        rx_bits.delete();
        hold = 1'b0;
    endtask

    task automatic inject(input logic [31:0] v);
        nonce_in    = v;
        nonce_valid = 1'b1;
        cycles(1);
        nonce_valid = 1'b0;
        cycles(2);
        if (pend_left == 0) begin
            push_stream(v);
            pend_left = 36;
        end else begin
            if (shad_v) drops_exp++;
            shad_v = 1'b1;
            shad_n = v;
        end
    endtask

    task automatic poll_check(input string name);
        logic [0:0] e;
        logic       got;
        e = 1'b0;
        if (exp_q.size() > 0) begin
            if (exp_q.size() <= pend_left) begin
                pend_left--;
                if (pend_left == 0 && shad_v) begin
                    push_stream(shad_n);
                    pend_left = 36;
                    shad_v    = 1'b0;
                end
            end
            e = exp_q.pop_front();
            tx_pos++;
        end
        TxC = 1'b1;
        cycles(5);
        got = TxD;
        TxC = 1'b0;
        cycles(3);
        checks++;
        if (got !== e[0]) begin
            errors++;
            $display("FAIL %s: TxD got %b expected %b (poll %0d)", name, got, e, tx_pos);
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            poll_check(name);
            guard++;
        end
        poll_check({name, "_idle0"});
        poll_check({name, "_idle1"});
    endtask

    task automatic check_drops(input string name);
`ifdef BITBANG_DROP_CNT_EN
        check(name, 256'(drop_cnt), 256'(drops_exp));
`else
        if (name.len() == 0) $display("drop check unnamed");
`endif
    endtask

    task automatic rand_word(output logic [511:0] w);
        for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
    endtask

    task automatic clear_model();
        model_mid  = '0;
        model_data = '0;
        rx_bits.delete();
        exp_q.delete();
        pend_left = 0;
        shad_v    = 1'b0;
        shad_n    = '0;
        tx_pos    = 0;
        drops_exp = 0;
    endtask

    initial begin
        logic [511:0] w;
        logic [35:0]  pin;
        int           nb;

        hold = 1'b1;
        rst_n = 1'b0;
        RxD = 1'b0; RxC = 1'b0; RxTxR = 1'b0; TxC = 1'b0;
        nonce_in = '0; nonce_valid = 1'b0;
        clear_model();
        cycles(3);
        check("rst_txd", 256'(TxD), 256'd0);
        check("rst_work_valid", 256'(work_valid), 256'd0);
        check("rst_tx_busy", 256'(tx_busy), 256'd0);
        check("rst_midstate", midstate, 256'd0);
        check("rst_data", data, 256'd0);
        rst_n = 1'b1;
        cycles(3);
        hold = 1'b0;
        check_drops("rst_drop_cnt");

        // Pin the readback stream model against a hand-expanded A966E1B9.
        push_stream(32'hA966E1B9);
        for (int i = 0; i < 36; i++) pin[35 - i] = exp_q[i];
        check("stream_pin", 256'(pin), 256'(36'b1_10010101_1_01100110_1_10000111_1_10011101));
        exp_q.delete();

        // Frame, write, commit
        w = {MID_VEC, DATA_VEC};
        pulse_rxtxr();
        send_word(w, 64);
        pulse_rxtxr();
        check("commit_pulses", 256'(wv_cycles), 256'd1);
        check("model_mid_hi", 256'(model_mid[255:224]), 256'(32'h2b3f8126));
        check("model_mid_lo", 256'(model_mid[31:0]), 256'(32'h2619c0b5));
        check("model_data_lo", 256'(model_data[95:0]), 256'(96'h39f3001b6b7b8d4dc14bfc31));
        check("midstate_vec", midstate, MID_VEC);
        check("data_vec", data, DATA_VEC);

        // Short frame, then a clean one
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 63);
        pulse_rxtxr();
        check("short_no_commit", 256'(wv_cycles), 256'd1);
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 64);
        pulse_rxtxr();
        check("after_short_commit", 256'(wv_cycles), 256'd2);

        // Overrun, then a clean one
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 64);
        send_byte(8'h5a);
        pulse_rxtxr();
        check("overrun_no_commit", 256'(wv_cycles), 256'd2);
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 64);
        pulse_rxtxr();
        check("after_overrun_commit", 256'(wv_cycles), 256'd3);

        // Single nonce readback
        inject(32'hA966E1B9);
        check("busy_after_nonce", 256'(tx_busy), 256'd1);
        for (int i = 0; i < 36; i++) poll_check("readback");
        check("busy_after_read", 256'(tx_busy), 256'd0);
        drain("readback_tail");

        // Back-to-back nonces with shadow overwrite
        inject(32'hA966E1B9);
        for (int i = 0; i < 3; i++) poll_check("b2b_a");
        inject(32'h11223344);
        for (int i = 0; i < 9; i++) poll_check("b2b_b");
        inject(32'h55667788);
        drain("b2b_c");
        check("b2b_busy", 256'(tx_busy), 256'd0);
        check_drops("b2b_drop_cnt");

        // Commit while byte 2 of a readback is on the wire
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 64);
        inject($urandom);
        for (int i = 0; i < 13; i++) poll_check("midread_pre");
        pulse_rxtxr();
        check("midread_commit", 256'(wv_cycles), 256'(exp_commits));
        drain("midread_post");
        check("midread_busy", 256'(tx_busy), 256'd0);
        check_drops("midread_drop_cnt");

        // Reset in the middle of a write
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 10);
        inject(32'hDEADBEEF);
        hold  = 1'b1;
        rst_n = 1'b0;
        cycles(1);
        clear_model();
        hold = 1'b0;
        cycles(1);
        check("mrst_txd", 256'(TxD), 256'd0);
        check("mrst_busy", 256'(tx_busy), 256'd0);
        check("mrst_midstate", midstate, 256'd0);
        check_drops("mrst_drop_cnt");
        rst_n = 1'b1;
        cycles(4);
        drain("mrst_tx");
        rand_word(w);
        pulse_rxtxr();
        send_word(w, 64);
        pulse_rxtxr();
        check("mrst_commit", 256'(wv_cycles), 256'(exp_commits));

        // Randomised frame lengths
        for (int r = 0; r < 3; r++) begin
            case ($urandom_range(0, 2))
                0:       nb = 512;
                1:       nb = $urandom_range(0, 511);
                default: nb = 512 + $urandom_range(1, 20);
            endcase
            pulse_rxtxr();
            for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
            pulse_rxtxr();
            check("rand_commits", 256'(wv_cycles), 256'(exp_commits));
        end

        // Randomised nonce bursts
        for (int r = 0; r < 3; r++) begin
            inject($urandom);
            if ($urandom_range(0, 1) == 1) inject($urandom);
            for (int i = 0; i < $urandom_range(0, 20); i++) poll_check("rand_nonce_a");
            drain("rand_nonce_b");
            check("rand_busy", 256'(tx_busy), 256'd0);
        end
        check_drops("final_drop_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitbang_host_if.md
Name: bitbang_host_if

Overview:
- Host-side serial front end of the doubled miner top; sits directly upstream and downstream of the hashing cores.
- Deserialises the host's bit-banged 64-byte work unit (32-byte midstate, then 32-byte data tail) and presents it to the cores with a one-cycle commit strobe.
- Captures golden nonces from the cores and shifts them back to the host over the TxC/TxD poll protocol.
- All host pins are asynchronous to clk and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flops per host-input synchroniser (minimum 2).
- WORK_BYTES, 64, bytes per work unit.
- NONCE_BYTES, 4, bytes per golden nonce.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RxD  in  1  host serial data, write direction.
- RxC  in  1  host write strobe; RxD is sampled on its rising edge.
- RxTxR  in  1  host frame/commit strobe.
- TxC  in  1  host read strobe; TxD is updated on its rising edge.
- TxD  out  1  serial data / data-available flag to the host.
- midstate  out  256  committed midstate; first byte received lands in [255:248].
- data  out  256  committed data tail; byte 33 received lands in [255:248].
- work_valid  out  1  one-cycle pulse when midstate/data update.
- nonce_in  in  32  golden nonce from the cores.
- nonce_valid  in  1  one-cycle qualifier for nonce_in.
- tx_busy  out  1  high while a nonce is pending or shifting.

Behaviour:
- Reset values: TxD=0, midstate=0, data=0, work_valid=0, tx_busy=0. Internally, all counters, the shift buffer and the pending/shadow slots are cleared.
- Synchronisers: RxD/RxC/RxTxR/TxC each pass through SYNC_STAGES flops. Edge detect uses one extra flop. Latency from pin to action is SYNC_STAGES+1 cycles.
- RX bit path: on each synced RxC rise, while byte_cnt<WORK_BYTES, shift synced RxD into the byte register, LSB first.
  - After the 8th bit, append the byte: buf <= {buf[503:0], byte}; then byte_cnt++.
- RX overrun: an RxC rise with byte_cnt==WORK_BYTES sets the sticky overrun flag and the bit is dropped.
- Commit: on a synced RxTxR rise, if byte_cnt==WORK_BYTES, bit_cnt==0 and no overrun, then:
  - load midstate<=buf[511:256] and data<=buf[255:0];
  - pulse work_valid for 1 cycle;
  - flush the pending and shadow nonce slots. A byte already mid-shift finishes.
- Framing reset: every RxTxR rise clears byte_cnt, bit_cnt and overrun, whether or not it commits.
- RxTxR and RxC rising in the same cycle: RxTxR wins and the RxC bit is discarded.
- TX FSM, states TX_IDLE and TX_BITS:
  - TX_IDLE, on synced TxC rise: if a nonce is pending with bytes_left>0, set TxD<=1 (data-available flag), load cur_byte from the next byte (MSB byte first: [31:24], [23:16], [15:8], [7:0]), bit_idx<=0, go to TX_BITS. Otherwise TxD<=0.
  - TX_BITS, on each TxC rise: TxD<=cur_byte[bit_idx], bit_idx++. After bit 7, bytes_left--, go to TX_IDLE.
  - Each byte therefore costs 9 TxC rises: 1 flag plus 8 data bits, LSB first.
  - When bytes_left reaches 0 and the shadow slot is full, the shadow moves to pending with bytes_left=NONCE_BYTES.
- Nonce capture:
  - nonce_valid with no pending nonce: load pending, bytes_left=NONCE_BYTES.
  - nonce_valid while pending: write the shadow slot; an occupied shadow is overwritten (newest wins) and a drop is recorded.
  - nonce_valid in the same cycle as a commit flush: the flush wins and the nonce is dropped.
- tx_busy = pending valid OR shadow valid OR state==TX_BITS.
- Reset asserted mid-transfer aborts both directions immediately and returns all outputs to their reset values.

Optional Feature:
- Macro: BITBANG_DROP_CNT_EN.
- When defined: adds output drop_cnt [7:0], a saturating count (stops at 255) of nonces lost to shadow overwrite or flush. Cleared only by reset.
- When undefined: no port and no counter; drops are silent.

Decomposition:
- Package bitbang_pkg holds: tx_state_t enum (TX_IDLE, TX_BITS), WORK_BITS=512, NONCE_BITS=32, and a BYTE_BITS=8 constant.
- One sub-module, bitbang_sync: a parameterised SYNC_STAGES synchroniser with a registered rising-edge pulse output. It is instantiated four times.

Test Plan:
- Frame, write, commit:
  - Stimulus: RxTxR pulse, then midstate 2b3f8126…2619c0b5 and data 00000000…39f3001b6b7b8d4dc14bfc31 (byte-MSB first, bit-LSB first), then an RxTxR pulse.
  - Required response: exactly one work_valid pulse; midstate/data equal the sent values.
- Short frame:
  - Stimulus: 63 bytes sent, then RxTxR.
  - Required response: no work_valid; outputs keep their previous values; the next full 64-byte frame commits correctly.
- Overrun:
  - Stimulus: 65 bytes sent, then RxTxR.
  - Required response: no commit; the following clean frame commits.
- Nonce readback:
  - Stimulus: nonce_valid with 32'hA966E1B9.
  - Required response: the host poll sees TxD=1, then bytes A9, 66, E1, B9 (each LSB first); subsequent polls return TxD=0; tx_busy falls after the last bit.
- Back-to-back nonces:
  - Stimulus: 0x11223344 during byte 1 of 0xA966E1B9, then 0x55667788 before the first nonce finishes.
  - Required response: the host reads A966E1B9 then 55667788; with BITBANG_DROP_CNT_EN, drop_cnt==1.
- Mid-read commit and reset:
  - Stimulus: commit during byte 2 of a readback; then assert rst_n low mid-write.
  - Required response: the current byte completes, then TxD=0 on the next poll; after reset, outputs are zero and a fresh frame commits normally.
